// File: rtl/simd_vector_unit.sv
// SIMD vector coprocessor: NREGS vector registers of LANES x WIDTH bits. One vector ALU op
// is executed per issue, PAR lanes per cycle, with per-lane write masking, per-lane zero
// flags and a sticky signed-overflow flag.
module simd_vector_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 8,
    parameter int unsigned PAR   = 2,
    parameter int unsigned NREGS = 8,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [2:0]               op,
    input  logic [RW-1:0]            vd,
    input  logic [RW-1:0]            vs,
    input  logic [RW-1:0]            vt,
    input  logic                     use_scalar,
    input  logic [WIDTH-1:0]         scalar,
    input  logic [LANES-1:0]         mask,
    output logic                     busy,
    output logic                     done,
    output logic [LANES-1:0]         zero_mask,
    output logic                     ovf_any,
    input  logic                     wr_en,
    input  logic [RW-1:0]            wr_reg,
    input  logic [LANES*WIDTH-1:0]   wr_data,
    input  logic [RW-1:0]            rd_reg,
    output logic [LANES*WIDTH-1:0]   rd_data
);

    localparam int unsigned NCH = LANES / PAR;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VW  = LANES * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_op;
    logic [RW-1:0]        r_vd;
    logic [RW-1:0]        r_vs;
    logic [RW-1:0]        r_vt;
    logic                 r_use_scalar;
    logic [WIDTH-1:0]     r_scalar;
    logic [LANES-1:0]     r_mask;
    logic [LANES-1:0]     r_zero_mask;
    logic                 r_ovf;
    logic [VW-1:0]        r_vreg [NREGS];

    logic [LW-1:0]        w_lane [PAR];
    logic [WIDTH-1:0]     w_a    [PAR];
    logic [WIDTH-1:0]     w_b    [PAR];
    logic [WIDTH-1:0]     w_res  [PAR];
    logic [PAR-1:0]       w_ovf;

    // Lane ALUs for the chunk selected by the chunk counter
    always_comb begin
        w_ovf = '0;
        for (int p = 0; p < PAR; p++) begin
            w_lane[p] = LW'(int'(r_cnt) * int'(PAR) + p);
            w_a[p]    = r_vreg[r_vs][int'(w_lane[p]) * WIDTH +: WIDTH];
            w_b[p]    = r_use_scalar ? r_scalar : r_vreg[r_vt][int'(w_lane[p]) * WIDTH +: WIDTH];
            w_res[p]  = '0;
            case (r_op)
                OP_ADD:  w_res[p] = w_a[p] + w_b[p];
                OP_SUB:  w_res[p] = w_a[p] - w_b[p];
                OP_XOR:  w_res[p] = w_a[p] ^ w_b[p];
                OP_SLT:  w_res[p] = WIDTH'($signed(w_a[p]) < $signed(w_b[p]));
                OP_AND:  w_res[p] = w_a[p] & w_b[p];
                OP_NAND: w_res[p] = ~(w_a[p] & w_b[p]);
                OP_NOR:  w_res[p] = ~(w_a[p] | w_b[p]);
                OP_OR:   w_res[p] = w_a[p] | w_b[p];
                default: w_res[p] = '0;
            endcase
            if (r_op == OP_ADD) begin
                w_ovf[p] = (w_a[p][WIDTH-1] == w_b[p][WIDTH-1]) &&
                           (w_res[p][WIDTH-1] != w_a[p][WIDTH-1]);
            end else if (r_op == OP_SUB) begin
                w_ovf[p] = (w_a[p][WIDTH-1] != w_b[p][WIDTH-1]) &&
                           (w_res[p][WIDTH-1] != w_a[p][WIDTH-1]);
            end
        end
    end

    // Control FSM, op latch, register file writes and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_vd         <= '0;
            r_vs         <= '0;
            r_vt         <= '0;
            r_use_scalar <= 1'b0;
            r_scalar     <= '0;
            r_mask       <= '0;
            r_zero_mask  <= '0;
            r_ovf        <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_vreg[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_en) begin
                        r_vreg[wr_reg] <= wr_data;
                    end
                    if (issue_valid) begin
                        r_op         <= op;
                        r_vd         <= vd;
                        r_vs         <= vs;
                        r_vt         <= vt;
                        r_use_scalar <= use_scalar;
                        r_scalar     <= scalar;
                        r_mask       <= mask;
                        r_ovf        <= 1'b0;
                        r_zero_mask  <= r_zero_mask & ~mask;
                        r_cnt        <= '0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    for (int p = 0; p < PAR; p++) begin
                        if (r_mask[w_lane[p]]) begin
                            r_vreg[r_vd][int'(w_lane[p]) * WIDTH +: WIDTH] <= w_res[p];
                            r_zero_mask[w_lane[p]] <= (w_res[p] == '0);
                            if (w_ovf[p]) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(NCH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign issue_ready = (r_state == S_IDLE);
    assign busy        = (r_state == S_EXEC) || (r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign zero_mask   = r_zero_mask;
    assign ovf_any     = r_ovf;
    assign rd_data     = r_vreg[rd_reg];

endmodule

// File: tb/tb_simd_vector_unit.sv
// Directed self-checking bench for simd_vector_unit (WIDTH=32, LANES=8, PAR=2, NREGS=8).
module tb_simd_vector_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned L  = 8;
    localparam int unsigned RW = 3;
    localparam int unsigned VW = L * W;

    logic           clk;
    logic           reset;
    logic           issue_valid;
    logic           issue_ready;
    logic [2:0]     op;
    logic [RW-1:0]  vd, vs, vt;
    logic           use_scalar;
    logic [W-1:0]   scalar;
    logic [L-1:0]   mask;
    logic           busy;
    logic           done;
    logic [L-1:0]   zero_mask;
    logic           ovf_any;
    logic           wr_en;
    logic [RW-1:0]  wr_reg;
    logic [VW-1:0]  wr_data;
    logic [RW-1:0]  rd_reg;
    logic [VW-1:0]  rd_data;

    int n_checks;
    int n_errors;
    logic [VW-1:0] e;
    logic [VW-1:0] e3;

    simd_vector_unit #(.WIDTH(32), .LANES(8), .PAR(2), .NREGS(8)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .vd(vd), .vs(vs), .vt(vt),
        .use_scalar(use_scalar), .scalar(scalar), .mask(mask),
        .busy(busy), .done(done), .zero_mask(zero_mask), .ovf_any(ovf_any),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [W-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] ramp(input logic [W-1:0] base);
        logic [VW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = base + W'(i);
        return r;
    endfunction

    task automatic host_write(input logic [RW-1:0] r, input logic [VW-1:0] d);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [RW-1:0] r, input logic [VW-1:0] exp);
        rd_reg = r;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic set_op(input logic [2:0] o, input logic [RW-1:0] d, input logic [RW-1:0] s,
                          input logic [RW-1:0] t, input logic us, input logic [W-1:0] sc,
                          input logic [L-1:0] m);
        op = o; vd = d; vs = s; vt = t; use_scalar = us; scalar = sc; mask = m;
    endtask

    task automatic issue();
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    // Bounded wait for completion: 4 EXEC cycles + 1 DONE cycle, exactly one done pulse
    task automatic wait_done(input string tag);
        int cyc;
        int dn;
        cyc = 0;
        dn  = 0;
        while (busy && cyc < 40) begin
            if (done) dn++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " busy_cycles"}, VW'(cyc), VW'(5));
        chk({tag, " done_pulses"}, VW'(dn), VW'(1));
    endtask

    task automatic run_op(input string tag);
        issue();
        chk({tag, " ready_low"}, VW'(issue_ready), VW'(0));
        wait_done(tag);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; issue_valid = 1'b0; wr_en = 1'b0; wr_reg = '0; wr_data = '0; rd_reg = '0;
        set_op(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, '0, '0);
        #12;
        chk("rst busy", VW'(busy), VW'(0));
        chk("rst done", VW'(done), VW'(0));
        chk("rst ready", VW'(issue_ready), VW'(1));
        chk("rst zero_mask", VW'(zero_mask), VW'(0));
        chk("rst ovf", VW'(ovf_any), VW'(0));
        read_chk("rst v3", 3'd3, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: ADD v3 = v1 + v2
        host_write(3'd1, ramp(32'd1));
        host_write(3'd2, splat(32'd10));
        set_op(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, '0, 8'hFF);
        run_op("t1");
        read_chk("t1 v3", 3'd3, ramp(32'd11));
        chk("t1 ovf", VW'(ovf_any), VW'(0));
        chk("t1 zero_mask", VW'(zero_mask), VW'(8'h00));

        // 2: SUB scalar in place, low four lanes only
        set_op(3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 32'd1, 8'h0F);
        run_op("t2");
        e = ramp(32'd1);
        for (int i = 0; i < 4; i++) e[i*W +: W] = W'(i);
        read_chk("t2 v1", 3'd1, e);
        chk("t2 zero_mask", VW'(zero_mask), VW'(8'h01));

        // 3: signed overflow on the single masked-in lane
        host_write(3'd4, splat(32'h7FFF_FFFF));
        set_op(3'd0, 3'd4, 3'd4, 3'd0, 1'b1, 32'd1, 8'h80);
        run_op("t3");
        e = splat(32'h7FFF_FFFF);
        e[7*W +: W] = 32'h8000_0000;
        read_chk("t3 v4", 3'd4, e);
        chk("t3 ovf", VW'(ovf_any), VW'(1));
        chk("t3 zero_mask", VW'(zero_mask), VW'(8'h01));

        // 4: SLT both directions; the accept clears the sticky overflow
        host_write(3'd5, splat(32'hFFFF_FFFF));
        host_write(3'd6, '0);
        set_op(3'd3, 3'd7, 3'd5, 3'd6, 1'b0, '0, 8'hFF);
        issue();
        chk("t4 ovf_cleared", VW'(ovf_any), VW'(0));
        wait_done("t4a");
        read_chk("t4 v7 lt", 3'd7, splat(32'd1));
        chk("t4 zero_mask lt", VW'(zero_mask), VW'(8'h00));
        set_op(3'd3, 3'd7, 3'd6, 3'd5, 1'b0, '0, 8'hFF);
        run_op("t4b");
        read_chk("t4 v7 ge", 3'd7, splat(32'd0));
        chk("t4 zero_mask ge", VW'(zero_mask), VW'(8'hFF));

        // NOR with zero scalar
        set_op(3'd6, 3'd2, 3'd6, 3'd0, 1'b1, 32'd0, 8'hFF);
        run_op("nor");
        read_chk("nor v2", 3'd2, splat(32'hFFFF_FFFF));
        chk("nor zero_mask", VW'(zero_mask), VW'(8'h00));

        // XOR with vd=vs=vt on lanes straddling chunk boundaries
        set_op(3'd2, 3'd3, 3'd3, 3'd3, 1'b0, '0, 8'h3C);
        run_op("xor");
        e3 = ramp(32'd11);
        for (int i = 2; i < 6; i++) e3[i*W +: W] = '0;
        read_chk("xor v3", 3'd3, e3);
        chk("xor zero_mask", VW'(zero_mask), VW'(8'h3C));

        // AND with scalar ~1 over v1 = {0,1,2,3,5,6,7,8}
        set_op(3'd4, 3'd6, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFE, 8'hFF);
        run_op("and");
        e = '0;
        e[2*W +: W] = 32'd2; e[3*W +: W] = 32'd2; e[4*W +: W] = 32'd4;
        e[5*W +: W] = 32'd6; e[6*W +: W] = 32'd6; e[7*W +: W] = 32'd8;
        read_chk("and v6", 3'd6, e);
        chk("and zero_mask", VW'(zero_mask), VW'(8'h03));

        // 5: held issue_valid, mask=0, host writes attempted while busy
        begin
            int acc;
            int dn;
            acc = 0;
            dn  = 0;
            set_op(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, '0, 8'h00);
            wr_reg = 3'd0;
            wr_data = splat(32'h5A5A_5A5A);
            issue_valid = 1'b1;
            for (int k = 0; k < 12; k++) begin
                if (issue_ready) acc++;
                wr_en = busy;
                @(posedge clk); #1;
                if (done) dn++;
            end
            issue_valid = 1'b0;
            wr_en = 1'b0;
            chk("t5 accepts", VW'(acc), VW'(2));
            chk("t5 done_pulses", VW'(dn), VW'(2));
        end
        read_chk("t5 v0", 3'd0, '0);
        read_chk("t5 v3", 3'd3, e3);
        chk("t5 zero_mask", VW'(zero_mask), VW'(8'h03));

        // Host write on the accept edge is seen by the op
        set_op(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 32'd5, 8'hFF);
        wr_reg = 3'd1; wr_data = splat(32'h100); wr_en = 1'b1;
        issue();
        wr_en = 1'b0;
        wait_done("same_edge");
        read_chk("same_edge v1", 3'd1, splat(32'h100));
        read_chk("same_edge v2", 3'd2, splat(32'h105));

        // 6: reset in the second EXEC cycle
        set_op(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, '0, 8'hFF);
        issue();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6 busy", VW'(busy), VW'(0));
        chk("t6 ready", VW'(issue_ready), VW'(1));
        chk("t6 done", VW'(done), VW'(0));
        chk("t6 ovf", VW'(ovf_any), VW'(0));
        for (int r = 0; r < 8; r++) read_chk($sformatf("t6 v%0d", r), RW'(r), '0);
        reset = 1'b0;
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            chk("t6 no_done", VW'(dn), VW'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
